// File: rtl/debug_controller.sv
// rtl/debug_controller.sv - host-side debug controller: command channel, loader, run control, breakpoints
module debug_controller #(
  parameter int NB_GPIO      = 32,
  parameter int NB_PC        = 32,
  parameter int N_REG        = 32,
  parameter int NB_INDEX     = $clog2(N_REG),
  parameter int NB_CHUNK     = 16,
  parameter int N_BREAK      = 4,
  parameter int RESET_CYCLES = 4
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [NB_GPIO-1:0]  i_gpio,
  input  logic [NB_PC-1:0]    i_mips_reg,
  input  logic [NB_PC-1:0]    i_mips_mem,
  input  logic [NB_PC-1:0]    i_mips_pc,
  output logic [NB_GPIO-1:0]  o_gpio,
  output logic                o_enable,
  output logic                o_mips_reset,
  output logic [NB_PC-1:0]    o_instruction_addr,
  output logic [NB_PC-1:0]    o_instruction_data,
  output logic                o_instruction_write_enb,
  output logic [NB_PC-1:0]    o_memory_addr,
  output logic [NB_INDEX-1:0] o_reg_index
);

  localparam int          N_CHUNK  = NB_PC / NB_CHUNK;
  localparam logic [15:0] RST_LOAD = 16'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {S_HALT, S_RUN, S_STEP, S_BREAK, S_RST} state_t;
  state_t state, state_next;

  logic               prev_toggle, cmd_valid, ack;
  logic [NB_GPIO-1:0] cmd;
  logic [6:0]         op;
  logic [3:0]         chunk, sub;
  logic [15:0]        data;
  logic [NB_CHUNK-1:0] payload;
  logic               chunk_ok, bp_ok, src_ok, cmd_err, exec, err_pulse;
  logic               do_clr, do_run, do_halt, do_step, do_rstp, do_iaddr, do_idata;
  logic               do_commit, do_ridx, do_maddr, do_bpaddr, do_bpen, do_read;

  logic [NB_PC-1:0]   bp_addr [N_BREAK];
  logic [N_BREAK-1:0] bp_en;
  logic               bp_match, match_eff, resume_mask;
  logic [1:0]         bp_hit, hit_idx;
  logic               break_hit, error;
  logic [15:0]        step_left, rst_left;
  logic [NB_PC-1:0]   en_count, snapshot, src_sel;
  logic [NB_CHUNK-1:0] rb_chunk;
  logic [6:0]         status;

  // Edge-detect the host toggle and hold the command word for one cycle of decode
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      prev_toggle <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd         <= '0;
    end else begin
      prev_toggle <= i_gpio[31];
      cmd_valid   <= i_gpio[31] ^ prev_toggle;
      cmd         <= i_gpio;
    end
  end

  assign op      = cmd[30:24];
  assign chunk   = cmd[23:20];
  assign sub     = cmd[19:16];
  assign data    = cmd[15:0];
  assign payload = data[NB_CHUNK-1:0];

  assign chunk_ok = {1'b0, chunk} < 5'(N_CHUNK);
  assign bp_ok    = {1'b0, sub} < 5'(N_BREAK);
  assign src_ok   = sub < 4'd4;

  // Validate the held command; a rejected command only raises the sticky error
  always_comb begin
    cmd_err = 1'b0;
    case (op)
      7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h08, 7'h09: cmd_err = 1'b0;
      7'h06, 7'h07, 7'h0A: cmd_err = !chunk_ok;
      7'h0B:               cmd_err = !chunk_ok || !bp_ok;
      7'h0C:               cmd_err = !bp_ok;
      7'h0D:               cmd_err = !chunk_ok || !src_ok;
      default:             cmd_err = 1'b1;
    endcase
  end

  assign exec      = cmd_valid && !cmd_err;
  assign err_pulse = cmd_valid && cmd_err;
  assign do_clr    = exec && (op == 7'h01);
  assign do_run    = exec && (op == 7'h02);
  assign do_halt   = exec && (op == 7'h03);
  assign do_step   = exec && (op == 7'h04);
  assign do_rstp   = exec && (op == 7'h05);
  assign do_iaddr  = exec && (op == 7'h06);
  assign do_idata  = exec && (op == 7'h07);
  assign do_commit = exec && (op == 7'h08);
  assign do_ridx   = exec && (op == 7'h09);
  assign do_maddr  = exec && (op == 7'h0A);
  assign do_bpaddr = exec && (op == 7'h0B);
  assign do_bpen   = exec && (op == 7'h0C);
  assign do_read   = exec && (op == 7'h0D);

  // Breakpoint compare against the live PC; scanning downward lets the lowest index win
  always_comb begin
    bp_match = 1'b0;
    bp_hit   = 2'd0;
    for (int k = N_BREAK - 1; k >= 0; k--) begin
      if (bp_en[k] && (bp_addr[k] == i_mips_pc)) begin
        bp_match = 1'b1;
        bp_hit   = 2'(k);
      end
    end
  end

  assign match_eff = bp_match && !resume_mask;

  // Run-control state register
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= S_HALT;
    else         state <= state_next;
  end

  // Run-control next state and core enable; a match blocks the instruction at the breakpoint
  always_comb begin
    state_next = state;
    o_enable   = 1'b0;
    if ((state == S_RUN) || (state == S_STEP)) o_enable = !match_eff;
    if (do_clr) begin
      state_next = S_HALT;
    end else if (do_rstp) begin
      state_next = S_RST;
    end else begin
      case (state)
        S_HALT, S_BREAK: begin
          if (do_run)       state_next = S_RUN;
          else if (do_step) state_next = S_STEP;
        end
        S_RUN: begin
          if (do_halt)        state_next = S_HALT;
          else if (match_eff) state_next = S_BREAK;
        end
        S_STEP: begin
          if (do_halt)                    state_next = S_HALT;
          else if (match_eff)             state_next = S_BREAK;
          else if (step_left == 16'd1)    state_next = S_HALT;
        end
        S_RST: begin
          if (rst_left == 16'd0) state_next = S_HALT;
        end
        default: state_next = S_HALT;
      endcase
    end
  end

  assign o_mips_reset = (state == S_RST);

  // Ack follows every accepted toggle, including CLR_ALL and rejected commands
  always_ff @(posedge i_clock) begin
    if (i_reset)        ack <= 1'b0;
    else if (cmd_valid) ack <= cmd[31];
  end

  always_comb begin
    case (sub[1:0])
      2'd0:    src_sel = i_mips_reg;
      2'd1:    src_sel = i_mips_mem;
      2'd2:    src_sel = i_mips_pc;
      default: src_sel = en_count;
    endcase
  end

  // Command side effects, loader, breakpoint table, readback and run-control bookkeeping
  always_ff @(posedge i_clock) begin
    if (i_reset || do_clr) begin
      o_instruction_addr      <= '0;
      o_instruction_data      <= '0;
      o_instruction_write_enb <= 1'b0;
      o_memory_addr           <= '0;
      o_reg_index             <= '0;
      for (int b = 0; b < N_BREAK; b++) bp_addr[b] <= '0;
      bp_en       <= '0;
      resume_mask <= 1'b0;
      hit_idx     <= 2'd0;
      break_hit   <= 1'b0;
      error       <= 1'b0;
      step_left   <= 16'd0;
      rst_left    <= 16'd0;
      en_count    <= '0;
      snapshot    <= '0;
      rb_chunk    <= '0;
    end else begin
      if (err_pulse) error <= 1'b1;

      if (o_enable) begin
        en_count    <= en_count + NB_PC'(1);
        resume_mask <= 1'b0;
        if (state == S_STEP) step_left <= step_left - 16'd1;
      end
      if ((state == S_RST) && (rst_left != 16'd0)) rst_left <= rst_left - 16'd1;

      if (((state == S_HALT) || (state == S_BREAK)) &&
          ((state_next == S_RUN) || (state_next == S_STEP))) begin
        break_hit   <= 1'b0;
        resume_mask <= (state == S_BREAK);
      end
      if ((state_next == S_STEP) && (state != S_STEP))
        step_left <= (data == 16'd0) ? 16'd1 : data;
      if ((state_next == S_BREAK) && (state != S_BREAK)) begin
        break_hit <= 1'b1;
        hit_idx   <= bp_hit;
      end
      if (do_rstp) begin
        rst_left <= RST_LOAD;
        en_count <= '0;
      end

      o_instruction_write_enb <= do_commit;
      if (o_instruction_write_enb) o_instruction_addr <= o_instruction_addr + NB_PC'(4);
      if (do_ridx) o_reg_index <= data[NB_INDEX-1:0];
      if (do_bpen) begin
        for (int b = 0; b < N_BREAK; b++)
          if (sub == 4'(b)) bp_en[b] <= data[0];
      end

      for (int k = 0; k < N_CHUNK; k++) begin
        if (chunk == 4'(k)) begin
          if (do_iaddr) o_instruction_addr[k*NB_CHUNK +: NB_CHUNK] <= payload;
          if (do_idata) o_instruction_data[k*NB_CHUNK +: NB_CHUNK] <= payload;
          if (do_maddr) o_memory_addr[k*NB_CHUNK +: NB_CHUNK]      <= payload;
          if (do_read)  rb_chunk <= snapshot[k*NB_CHUNK +: NB_CHUNK];
          if (do_bpaddr) begin
            for (int b = 0; b < N_BREAK; b++)
              if (sub == 4'(b)) bp_addr[b][k*NB_CHUNK +: NB_CHUNK] <= payload;
          end
        end
      end
      if (do_read && (chunk == 4'd0)) begin
        snapshot <= src_sel;
        rb_chunk <= src_sel[NB_CHUNK-1:0];
      end
    end
  end

  assign status = {error, hit_idx, (state == S_RST), break_hit, (state == S_STEP), (state == S_RUN)};

  // Host-visible word: ack toggle, status, readback chunk, zeros elsewhere
  always_comb begin
    o_gpio                 = '0;
    o_gpio[31]             = ack;
    o_gpio[30:24]          = status;
    o_gpio[NB_CHUNK-1:0]   = rb_chunk;
  end

endmodule
